// File: rtl/nes_video_pkg.sv
// ============================================================
// nes_video_pkg : shared palette-loader types and constants
// Rev 1.0
// ============================================================
`default_nettype none

package nes_video_pkg;

  localparam int         PAL_ENTRIES    = 64;
  localparam int         PAL_BYTES      = 192;
  localparam logic [7:0] PAL_FILE_INDEX = 8'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic [1:0] {
    PAL_IDLE    = 2'd0,
    PAL_COLLECT = 2'd1,
    PAL_WRITE   = 2'd2,
    PAL_DONE    = 2'd3
  } pal_ld_state_t;

endpackage

`default_nettype wire

// File: rtl/pal_loader.sv
// ============================================================
// pal_loader : turns an ioctl palette download into palette RAM writes
// Rev 1.0
// ============================================================
`default_nettype none

module pal_loader
  import nes_video_pkg::*;
#(
  parameter logic [7:0] FILE_INDEX = PAL_FILE_INDEX,
  parameter int         ENTRIES    = PAL_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        load_color,
  output logic [23:0] load_color_data,
  output logic [5:0]  load_color_index,
  output logic        pal_loaded,
  output logic        pal_error
);

  localparam logic [6:0] ENTRIES_W = 7'(ENTRIES);

  pal_ld_state_t state, state_next;
  logic        dl_prev;
  logic [1:0]  byte_cnt;
  logic [6:0]  entry_cnt;
  logic [7:0]  r_byte, g_byte;
  rgb24_t      color_q;
  logic [5:0]  index_q;
  logic        loaded_q, error_q;

  logic        dl_rise, dl_fall, start, last_entry, taking, addr_ok, accept, bad;
  logic [6:0]  entry_eff;
  logic [24:0] exp_addr;

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign dl_fall    = ~ioctl_download & dl_prev;
  assign start      = (state == PAL_IDLE) && dl_rise && (ioctl_index == FILE_INDEX);
  assign last_entry = (entry_cnt + 7'd1) == ENTRIES_W;

  // During WRITE the entry counter has not yet advanced, so an incoming byte
  // is checked against byte 0 of the following entry.
  assign entry_eff = (state == PAL_WRITE) ? entry_cnt + 7'd1 : entry_cnt;
  assign exp_addr  = 25'(entry_eff) * 25'd3 + 25'(byte_cnt);
  assign addr_ok   = (ioctl_addr == exp_addr);
  assign taking    = ioctl_wr && !dl_fall &&
                     ((state == PAL_COLLECT) || ((state == PAL_WRITE) && !last_entry));
  assign accept    = taking && addr_ok;
  assign bad       = taking && !addr_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= PAL_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PAL_IDLE:    if (start) state_next = PAL_COLLECT;
      PAL_COLLECT: begin
        if (dl_fall)                          state_next = PAL_IDLE;
        else if (accept && byte_cnt == 2'd2)  state_next = PAL_WRITE;
      end
      PAL_WRITE: begin
        if (dl_fall)         state_next = PAL_IDLE;
        else if (last_entry) state_next = PAL_DONE;
        else                 state_next = PAL_COLLECT;
      end
      PAL_DONE:    if (dl_fall) state_next = PAL_IDLE;
      default:     state_next = PAL_IDLE;
    endcase
  end

  always_comb begin
    load_color = (state == PAL_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Treat download as already high so a transfer in progress cannot re-arm.
      dl_prev   <= 1'b1;
      byte_cnt  <= 2'd0;
      entry_cnt <= 7'd0;
      r_byte    <= 8'd0;
      g_byte    <= 8'd0;
      color_q   <= '0;
      index_q   <= 6'd0;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      if (start) begin
        byte_cnt  <= 2'd0;
        entry_cnt <= 7'd0;
        loaded_q  <= 1'b0;
        error_q   <= 1'b0;
      end
      if (accept) begin
        case (byte_cnt)
          2'd0: begin r_byte <= ioctl_dout; byte_cnt <= 2'd1; end
          2'd1: begin g_byte <= ioctl_dout; byte_cnt <= 2'd2; end
          2'd2: begin
            color_q  <= '{r: r_byte, g: g_byte, b: ioctl_dout};
            index_q  <= entry_cnt[5:0];
            byte_cnt <= 2'd0;
          end
          default: byte_cnt <= 2'd0;
        endcase
      end
      if (state == PAL_WRITE) entry_cnt <= entry_cnt + 7'd1;
      if (bad) error_q <= 1'b1;
      if (dl_fall) begin
        if (state == PAL_DONE)                                  loaded_q <= 1'b1;
        else if (state == PAL_COLLECT || state == PAL_WRITE)    error_q  <= 1'b1;
      end
    end
  end

  assign load_color_data  = color_q;
  assign load_color_index = index_q;
  assign pal_loaded       = loaded_q;
  assign pal_error        = error_q;

endmodule

`default_nettype wire

// File: tb/tb_pal_loader.sv
// ============================================================
// tb_pal_loader : randomized palette downloads against a file-walk model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pal_loader;

  localparam logic [7:0] PAL_IDX   = 8'd2;
  localparam int         FILE_SIZE = 192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        load_color;
  logic [23:0] load_color_data;
  logic [5:0]  load_color_index;
  logic        pal_loaded;
  logic        pal_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0]  got_idx[$];
  logic [23:0] got_dat[$];
  logic [5:0]  exp_idx[$];
  logic [23:0] exp_dat[$];
  logic        prev_lc = 1'b0;
  logic        m_loaded = 1'b0;
  logic        m_error = 1'b0;

  pal_loader dut (
    .clk              (clk),
    .reset            (reset),
    .ioctl_download   (ioctl_download),
    .ioctl_index      (ioctl_index),
    .ioctl_wr         (ioctl_wr),
    .ioctl_addr       (ioctl_addr),
    .ioctl_dout       (ioctl_dout),
    .load_color       (load_color),
    .load_color_data  (load_color_data),
    .load_color_index (load_color_index),
    .pal_loaded       (pal_loaded),
    .pal_error        (pal_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_color) begin
      chk("pulse_width", {31'd0, prev_lc}, 32'd0);
      got_idx.push_back(load_color_index);
      got_dat.push_back(load_color_data);
    end
    prev_lc = load_color;
  end

  // Model: walk the file in order; each in-order byte advances the file
  // position, a complete triplet becomes an entry, bytes past 192 are ignored.
  task automatic run_dl(input string name, input logic [7:0] idx, input int nbytes,
                        input int gmin, input int gmax, input bit addr_data,
                        input int skip_at, input int rst_at);
    int          p;
    bit          err;
    bit          dead;
    logic [7:0]  trip [3];
    logic [24:0] a;
    logic [7:0]  d;
    int          gap;
    got_idx.delete(); got_dat.delete();
    exp_idx.delete(); exp_dat.delete();
    p = 0; err = 1'b0; dead = (idx != PAL_IDX);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dead = 1'b1;
        m_loaded = 1'b0;
        m_error = 1'b0;
      end
      a = (skip_at >= 0 && i >= skip_at) ? 25'(i + 1) : 25'(i);
      d = addr_data ? a[7:0] : 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      @(negedge clk);
      ioctl_wr = 1'b0;
      gap = int'($urandom_range(gmax, gmin));
      repeat (gap - 1) @(negedge clk);
      if (!dead && p < FILE_SIZE) begin
        if (a != 25'(p)) err = 1'b1;
        else begin
          trip[p % 3] = d;
          p++;
          if (p % 3 == 0) begin
            exp_idx.push_back(6'(p / 3 - 1));
            exp_dat.push_back({trip[0], trip[1], trip[2]});
          end
        end
      end
    end
    repeat (4) @(negedge clk);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk);
    if (!dead) begin
      m_loaded = (p == FILE_SIZE);
      m_error  = err || (p < FILE_SIZE);
    end
    chk({name, ".n_pulses"}, 32'(got_idx.size()), 32'(exp_idx.size()));
    for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
      chk($sformatf("%s.idx[%0d]", name, k), 32'(got_idx[k]), 32'(exp_idx[k]));
      chk($sformatf("%s.dat[%0d]", name, k), 32'(got_dat[k]), 32'(exp_dat[k]));
    end
    chk({name, ".pal_loaded"}, {31'd0, pal_loaded}, {31'd0, m_loaded});
    chk({name, ".pal_error"},  {31'd0, pal_error},  {31'd0, m_error});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.load_color", {31'd0, load_color}, 32'd0);
    chk("rst.data",       32'(load_color_data), 32'd0);
    chk("rst.index",      32'(load_color_index), 32'd0);
    chk("rst.pal_loaded", {31'd0, pal_loaded}, 32'd0);
    chk("rst.pal_error",  {31'd0, pal_error}, 32'd0);
    repeat (2) @(negedge clk);

    run_dl("full192",  PAL_IDX, 192,  4, 4, 1'b1, -1, -1);
    chk("full192.first", (exp_dat.size() > 0) ? 32'(exp_dat[0]) : 32'hFFFF_FFFF, 32'h000102);
    chk("full192.last",  (got_dat.size() == 64) ? 32'(got_dat[63]) : 32'hFFFF_FFFF, 32'hBDBEBF);
    run_dl("big1536",  PAL_IDX, 1536, 2, 3, 1'b0, -1, -1);
    run_dl("short100", PAL_IDX, 100,  2, 4, 1'b0, -1, -1);
    run_dl("b2b",      PAL_IDX, 192,  2, 2, 1'b0, -1, -1);
    run_dl("skip10",   PAL_IDX, 192,  2, 5, 1'b1, 10, -1);
    run_dl("idx1",     8'd1,    192,  2, 4, 1'b0, -1, -1);
    run_dl("rst_e20",  PAL_IDX, 192,  2, 4, 1'b0, -1, 61);
    run_dl("restart",  PAL_IDX, 192,  1, 3, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
